pe_add_sched: RTL and testbench

- Round-robin scheduler that shares one 64-bit carry-lookahead adder datapath among NREQ processing-element requesters.
- Accepts add requests over a valid/ready handshake and issues at most one per cycle to the adder.
- Tracks in-flight operations through the adder latency and returns each result, tagged, to its originator.
- Keeps a per-requester carry register so that multi-word (e.g. 128-bit) adds can be chained across successive requests.

---
 rtl/pe_pkg.sv | 15 +
 rtl/pe_rr_arb.sv | 41 ++++
 rtl/pe_add_sched.sv | 134 +++++++++++++
 tb/tb_pe_add_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and types for the shared-adder scheduler.
//   PE_W     operand width
//   PE_NREQ  default number of requesters
//   PE_IDW   requester id width (clog2 of PE_NREQ)
//   pe_tag_t one tag-pipeline entry: valid bit plus originating requester id
package pe_pkg;
   localparam int PE_W    = 64;
   localparam int PE_NREQ = 4;
   localparam int PE_IDW  = $clog2(PE_NREQ);

   typedef struct packed {
      logic              v;
      logic [PE_IDW-1:0] id;
   } pe_tag_t;
endpackage

// File: rtl/pe_rr_arb.sv
// pe_rr_arb: combinational round-robin arbiter.
//   i_elig  per-requester eligibility
//   i_rr    requester with highest priority this cycle (always < NREQ)
//   o_gnt   one-hot grant, zero when nothing is eligible
//   o_gidx  index of the granted requester (0 when none)
//   o_any   some requester was granted
module pe_rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] i_elig,
   input  logic [IDW-1:0]  i_rr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_gidx,
   output logic            o_any
);
   // Each candidate's priority is its wrap-around distance from i_rr; the
   // eligible candidate with the smallest distance wins. This works for any
   // NREQ, not just powers of two.
   always_comb begin
      int w_dist;
      int w_best;
      w_dist = 0;
      w_best = NREQ;
      o_gidx = '0;
      for (int c = 0; c < NREQ; c++) begin
         if (c >= int'(i_rr))
            w_dist = c - int'(i_rr);
         else
            w_dist = c + NREQ - int'(i_rr);
         if (i_elig[c] && (w_dist < w_best)) begin
            w_best = w_dist;
            o_gidx = IDW'(c);
         end
      end
      o_any = (w_best < NREQ);
      o_gnt = '0;
      for (int c = 0; c < NREQ; c++)
         o_gnt[c] = o_any && (o_gidx == IDW'(c));
   end
endmodule

// File: rtl/pe_add_sched.sv
// pe_add_sched: round-robin scheduler sharing one external W-bit adder among
// NREQ requesters, with per-requester carry storage for multi-word chaining.
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_a/req_b          packed operands, requester i at [i*W +: W]
//   req_cin/req_chain    explicit carry-in / use stored carry instead
//   add_issue/add_a/add_b/add_cin  operands to the adder (combinational)
//   add_sum/add_cout     adder result, ADD_LAT cycles after issue
//   rsp_valid/rsp_id/rsp_sum/rsp_cout  registered, tagged result
//   busy                 any operation in the tag pipeline or response register
// The tag pipeline uses pe_tag_t, so IDW must equal pe_pkg::PE_IDW.
module pe_add_sched
   import pe_pkg::*;
#(
   parameter int NREQ    = PE_NREQ,
   parameter int IDW     = PE_IDW,
   parameter int W       = PE_W,
   parameter int ADD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ-1:0]   req_cin,
   input  logic [NREQ-1:0]   req_chain,
   output logic              add_issue,
   output logic [W-1:0]      add_a,
   output logic [W-1:0]      add_b,
   output logic              add_cin,
   input  logic [W-1:0]      add_sum,
   input  logic              add_cout,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_sum,
   output logic              rsp_cout,
   output logic              busy
);
   logic [IDW-1:0]  r_rr;
   logic [NREQ-1:0] r_carry;
   pe_tag_t         r_tag [ADD_LAT];
   logic            r_rsp_valid;
   logic [IDW-1:0]  r_rsp_id;
   logic [W-1:0]    r_rsp_sum;
   logic            r_rsp_cout;

   logic [NREQ-1:0] w_pend;
   logic [NREQ-1:0] w_elig;
   logic [NREQ-1:0] w_gnt;
   logic [IDW-1:0]  w_gidx;
   logic            w_fire;
   logic            w_busy;
   pe_tag_t         w_last;

   // A requester stays pending from issue until its response has been
   // presented, which is exactly when its stored carry becomes current.
   always_comb begin
      w_pend = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_rsp_valid && (r_rsp_id == IDW'(i)))
            w_pend[i] = 1'b1;
         for (int s = 0; s < ADD_LAT; s++)
            if (r_tag[s].v && (r_tag[s].id == IDW'(i)))
               w_pend[i] = 1'b1;
      end
   end

   assign w_elig = req_valid & ~(req_chain & w_pend);

   pe_rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .i_elig (w_elig),
      .i_rr   (r_rr),
      .o_gnt  (w_gnt),
      .o_gidx (w_gidx),
      .o_any  (w_fire)
   );

   // Grant implies valid, so any grant is a completed handshake.
   assign req_ready = w_gnt;
   assign add_issue = w_fire;
   assign add_a     = w_fire ? req_a[w_gidx*W +: W] : '0;
   assign add_b     = w_fire ? req_b[w_gidx*W +: W] : '0;
   assign add_cin   = w_fire & (req_chain[w_gidx] ? r_carry[w_gidx] : req_cin[w_gidx]);

   assign w_last = r_tag[ADD_LAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr        <= '0;
         r_carry     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_sum   <= '0;
         r_rsp_cout  <= 1'b0;
         for (int s = 0; s < ADD_LAT; s++)
            r_tag[s] <= '0;
      end else begin
         if (w_fire)
            r_rr <= (w_gidx == IDW'(NREQ-1)) ? '0 : w_gidx + 1'b1;

         r_tag[0].v  <= w_fire;
         r_tag[0].id <= w_gidx;
         for (int s = 1; s < ADD_LAT; s++)
            r_tag[s] <= r_tag[s-1];

         // Adder output lines up with the last tag stage.
         r_rsp_valid <= w_last.v;
         if (w_last.v) begin
            r_rsp_id   <= w_last.id;
            r_rsp_sum  <= add_sum;
            r_rsp_cout <= add_cout;
         end
         for (int i = 0; i < NREQ; i++)
            if (w_last.v && (w_last.id == IDW'(i)))
               r_carry[i] <= add_cout;
      end
   end

   always_comb begin
      w_busy = r_rsp_valid;
      for (int s = 0; s < ADD_LAT; s++)
         w_busy = w_busy | r_tag[s].v;
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_sum   = r_rsp_sum;
   assign rsp_cout  = r_rsp_cout;
   assign busy      = w_busy;
endmodule

// File: tb/tb_pe_add_sched.sv
// tb_pe_add_sched: directed bench for pe_add_sched. One instance uses
// ADD_LAT=1, a second uses ADD_LAT=3; each is paired with a behavioural adder.
module tb_pe_add_sched;
   localparam int N   = 4;
   localparam int W   = 64;
   localparam int IDW = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ADD_LAT = 1 instance
   logic [N-1:0]   v1, rdy1, cin1, chain1;
   logic [N*W-1:0] a1, b1;
   logic           issue1, add_cin1, cout1;
   logic [W-1:0]   add_a1, add_b1, sum1;
   logic           rsp_v1, rsp_cout1, busy1;
   logic [IDW-1:0] rsp_id1;
   logic [W-1:0]   rsp_sum1;

   // ADD_LAT = 3 instance
   logic [N-1:0]   v3, rdy3, cin3, chain3;
   logic [N*W-1:0] a3, b3;
   logic           issue3, add_cin3, cout3;
   logic [W-1:0]   add_a3, add_b3, sum3;
   logic           rsp_v3, rsp_cout3, busy3;
   logic [IDW-1:0] rsp_id3;
   logic [W-1:0]   rsp_sum3;

   pe_add_sched #(.NREQ(N), .IDW(IDW), .W(W), .ADD_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req_valid(v1), .req_ready(rdy1), .req_a(a1), .req_b(b1),
      .req_cin(cin1), .req_chain(chain1),
      .add_issue(issue1), .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
      .add_sum(sum1), .add_cout(cout1),
      .rsp_valid(rsp_v1), .rsp_id(rsp_id1), .rsp_sum(rsp_sum1), .rsp_cout(rsp_cout1),
      .busy(busy1)
   );

   pe_add_sched #(.NREQ(N), .IDW(IDW), .W(W), .ADD_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .req_valid(v3), .req_ready(rdy3), .req_a(a3), .req_b(b3),
      .req_cin(cin3), .req_chain(chain3),
      .add_issue(issue3), .add_a(add_a3), .add_b(add_b3), .add_cin(add_cin3),
      .add_sum(sum3), .add_cout(cout3),
      .rsp_valid(rsp_v3), .rsp_id(rsp_id3), .rsp_sum(rsp_sum3), .rsp_cout(rsp_cout3),
      .busy(busy3)
   );

   // External adders: 1-stage and 3-stage pipelined W-bit add with carry.
   always_ff @(posedge clk)
      {cout1, sum1} <= {1'b0, add_a1} + {1'b0, add_b1} + {{W{1'b0}}, add_cin1};

   logic [W:0] pipe3 [3];
   always_ff @(posedge clk) begin
      pipe3[0] <= {1'b0, add_a3} + {1'b0, add_b3} + {{W{1'b0}}, add_cin3};
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign {cout3, sum3} = pipe3[2];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set1(input int i, input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin, input logic chain);
      v1[i]          = v;
      a1[i*W +: W]   = a;
      b1[i*W +: W]   = b;
      cin1[i]        = cin;
      chain1[i]      = chain;
   endtask

   task automatic clr1();
      v1 = '0; cin1 = '0; chain1 = '0; a1 = '0; b1 = '0;
   endtask

   // Operand table with hand-computed sums/carries (cin = 0).
   logic [W-1:0] a_tab [N];
   logic [W-1:0] b_tab [N];
   logic [W-1:0] s_tab [N];
   logic         c_tab [N];

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      a_tab[0] = 64'h1111_0000_0000_0001; b_tab[0] = 64'h1;
      s_tab[0] = 64'h1111_0000_0000_0002; c_tab[0] = 1'b0;
      a_tab[1] = 64'hFFFF_FFFF_FFFF_FFFF; b_tab[1] = 64'h2;
      s_tab[1] = 64'h0000_0000_0000_0001; c_tab[1] = 1'b1;
      a_tab[2] = 64'h8000_0000_0000_0000; b_tab[2] = 64'h8000_0000_0000_0000;
      s_tab[2] = 64'h0;                   c_tab[2] = 1'b1;
      a_tab[3] = 64'h0123_4567_89AB_CDEF; b_tab[3] = 64'h1111_1111_1111_1111;
      s_tab[3] = 64'h1234_5678_9ABC_DF00; c_tab[3] = 1'b0;

      rst = 1'b1;
      clr1();
      v3 = '0; cin3 = '0; chain3 = '0; a3 = '0; b3 = '0;
      repeat (3) step();
      chk("reset rsp_valid", rsp_v1, 0);
      chk("reset busy", busy1, 0);
      chk("reset rsp_sum", rsp_sum1, 0);
      chk("reset ready", rdy1, 0);
      chk("reset issue", issue1, 0);
      rst = 1'b0;

      // Single op on req 0: all-ones + 1 wraps to 0 with carry out.
      set1(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      #1;
      chk("t1 ready", rdy1, 4'b0001);
      chk("t1 issue", issue1, 1);
      chk("t1 add_a", add_a1, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t1 add_b", add_b1, 64'h1);
      chk("t1 add_cin", add_cin1, 0);
      step(); clr1();
      chk("t1 rsp_valid T+1", rsp_v1, 0);
      chk("t1 busy T+1", busy1, 1);
      #1;
      chk("t1 idle add_a", add_a1, 0);
      step();
      chk("t1 rsp_valid T+2", rsp_v1, 1);
      chk("t1 rsp_id", rsp_id1, 0);
      chk("t1 rsp_sum", rsp_sum1, 0);
      chk("t1 rsp_cout", rsp_cout1, 1);
      // Stored carry[0]=1 shows up as add_cin of a chained op: 0+0+1.
      step();
      set1(0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b1);
      #1;
      chk("t1 chain ready", rdy1, 4'b0001);
      chk("t1 chain add_cin", add_cin1, 1);
      step(); clr1();
      step();
      chk("t1 chain rsp_valid", rsp_v1, 1);
      chk("t1 chain rsp_sum", rsp_sum1, 64'h1);
      chk("t1 chain rsp_cout", rsp_cout1, 0);

      // Round robin: all four valid for 8 cycles after a fresh reset.
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k < 8) begin
            for (int i = 0; i < N; i++)
               set1(i, 1'b1, a_tab[i], b_tab[i], 1'b0, 1'b0);
         end else begin
            clr1();
         end
         #1;
         chk($sformatf("rr ready c%0d", k), rdy1, (k < 8) ? (64'd1 << (k % 4)) : 64'd0);
         step();
         if (k >= 1 && k <= 8) begin
            chk($sformatf("rr rsp_valid c%0d", k + 1), rsp_v1, 1);
            chk($sformatf("rr rsp_id c%0d", k + 1), rsp_id1, 64'((k - 1) % 4));
            chk($sformatf("rr rsp_sum c%0d", k + 1), rsp_sum1, s_tab[(k - 1) % 4]);
            chk($sformatf("rr rsp_cout c%0d", k + 1), rsp_cout1, c_tab[(k - 1) % 4]);
         end
      end
      chk("rr drained rsp_valid", rsp_v1, 0);
      chk("rr drained busy", busy1, 0);

      // 128-bit add on req 2: high word must wait for the low word's carry.
      set1(2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      #1;
      chk("w128 lo ready", rdy1, 4'b0100);
      step();
      set1(2, 1'b1, 64'h0, 64'h0, 1'b0, 1'b1);
      #1;
      chk("w128 hi stall c1", rdy1, 4'b0000);
      step();
      chk("w128 lo rsp_valid", rsp_v1, 1);
      chk("w128 lo rsp_id", rsp_id1, 2);
      chk("w128 lo rsp_sum", rsp_sum1, 0);
      chk("w128 lo rsp_cout", rsp_cout1, 1);
      #1;
      chk("w128 hi stall c2", rdy1, 4'b0000);
      step();
      #1;
      chk("w128 hi ready c3", rdy1, 4'b0100);
      chk("w128 hi add_cin", add_cin1, 1);
      step(); clr1();
      step();
      chk("w128 hi rsp_id", rsp_id1, 2);
      chk("w128 hi rsp_sum", rsp_sum1, 64'h1);
      chk("w128 hi rsp_cout", rsp_cout1, 0);

      // Chain hazard: req 1 chained (pending) while req 3 plain goes ahead.
      set1(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      #1;
      chk("hz req1 first ready", rdy1, 4'b0010);
      step();
      set1(1, 1'b1, 64'd5, 64'd6, 1'b0, 1'b1);
      set1(3, 1'b1, 64'd10, 64'd20, 1'b0, 1'b0);
      #1;
      chk("hz req3 bypass ready", rdy1, 4'b1000);
      step();
      chk("hz req1 rsp_id", rsp_id1, 1);
      chk("hz req1 rsp_cout", rsp_cout1, 1);
      v1[3] = 1'b0;
      #1;
      chk("hz req1 still stalled", rdy1, 4'b0000);
      step();
      chk("hz req3 rsp_id", rsp_id1, 3);
      chk("hz req3 rsp_sum", rsp_sum1, 64'd30);
      #1;
      chk("hz req1 ready after rsp", rdy1, 4'b0010);
      chk("hz req1 add_cin", add_cin1, 1);
      step(); clr1();
      step();
      chk("hz req1 chain rsp_id", rsp_id1, 1);
      chk("hz req1 chain rsp_sum", rsp_sum1, 64'd12);

      // Reset with operations in flight; req 2's op sets carry[2]=1 first.
      for (int i = 0; i < N; i++)
         set1(i, 1'b1, a_tab[i], b_tab[i], 1'b0, 1'b0);
      #1;
      chk("rst pre ready c0", rdy1, 4'b0100);
      step();
      #1;
      chk("rst pre ready c1", rdy1, 4'b1000);
      step();
      clr1();
      chk("rst pre busy", busy1, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst rsp_valid", rsp_v1, 0);
      chk("rst busy", busy1, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("rst no rsp c%0d", k), rsp_v1, 0);
      end
      for (int i = 0; i < N; i++)
         set1(i, 1'b1, a_tab[i], b_tab[i], 1'b0, 1'b0);
      #1;
      chk("rst rr pointer 0", rdy1, 4'b0001);
      step(); clr1();
      set1(2, 1'b1, 64'h0, 64'h0, 1'b0, 1'b1);
      #1;
      chk("rst carry2 ready", rdy1, 4'b0100);
      chk("rst carry2 cleared", add_cin1, 0);
      step(); clr1();
      repeat (3) step();

      // ADD_LAT = 3: back-to-back from req 0 then req 1.
      v3 = 4'b0011;
      a3[0 +: W] = 64'd7;                  b3[0 +: W] = 64'd8;   cin3[0] = 1'b1;
      a3[W +: W] = 64'hFFFF_FFFF_FFFF_FFFE; b3[W +: W] = 64'd1;  cin3[1] = 1'b1;
      #1;
      chk("lat3 ready T", rdy3, 4'b0001);
      chk("lat3 add_cin T", add_cin3, 1);
      step();
      v3[0] = 1'b0;
      #1;
      chk("lat3 ready T+1", rdy3, 4'b0010);
      step();
      v3 = '0;
      chk("lat3 rsp_valid T+2", rsp_v3, 0);
      step();
      chk("lat3 rsp_valid T+3", rsp_v3, 0);
      chk("lat3 busy T+3", busy3, 1);
      step();
      chk("lat3 rsp_valid T+4", rsp_v3, 1);
      chk("lat3 rsp_id T+4", rsp_id3, 0);
      chk("lat3 rsp_sum T+4", rsp_sum3, 64'd16);
      chk("lat3 rsp_cout T+4", rsp_cout3, 0);
      step();
      chk("lat3 rsp_valid T+5", rsp_v3, 1);
      chk("lat3 rsp_id T+5", rsp_id3, 1);
      chk("lat3 rsp_sum T+5", rsp_sum3, 64'h0);
      chk("lat3 rsp_cout T+5", rsp_cout3, 1);
      step();
      chk("lat3 rsp_valid T+6", rsp_v3, 0);
      chk("lat3 busy T+6", busy3, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
